// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: FSM encoding,
// per-step limit and the bit layout of the latched mode vector.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Largest amount one shift_step pass can apply.
  localparam int STEP_MAX = 3;

  localparam int MODE_SHIFT = 0;
  localparam int MODE_ARITH = 1;
  localparam int MODE_LEFT  = 2;
  localparam int MODE_W     = 3;

  // Portion of the remaining amount to consume this cycle.
  function automatic logic [1:0] step_amount(input logic [31:0] remaining);
    if (remaining > 32'(STEP_MAX)) begin
      return 2'(STEP_MAX);
    end
    return remaining[1:0];
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational rotate/shift pass of 0..3 bit positions.
// Rotates use a doubled copy of the word; right shifts use a sign/zero extended copy.
module shift_step #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        k,
  input  logic              left,
  input  logic              arith,
  input  logic              shift,
  output logic [DATA_W-1:0] data_out
);

  logic              fill;
  logic [2*DATA_W-1:0] dbl;
  logic [2*DATA_W-1:0] ext;
  logic [2*DATA_W-1:0] rot_l;
  logic [2*DATA_W-1:0] rot_r;
  logic [2*DATA_W-1:0] shr;

  // Vacated bits on a right shift take the sign only in arithmetic mode.
  assign fill  = arith & data[DATA_W-1];
  assign dbl   = {data, data};
  assign ext   = {{DATA_W{fill}}, data};
  assign rot_l = dbl << k;
  assign rot_r = dbl >> k;
  assign shr   = ext >> k;

  always_comb begin
    data_out = data;
    if (!shift) begin
      if (left) begin
        data_out = rot_l[2*DATA_W-1:DATA_W];
      end else begin
        data_out = rot_r[DATA_W-1:0];
      end
    end else if (left) begin
      data_out = data << k;
    end else begin
      data_out = shr[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: splits a large shift/rotate amount into steps of
// at most STEP_MAX and iterates one shift_step, with valid/ready on both sides.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_left,
  input  logic              in_arith,
  input  logic              in_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic [1:0]          step_k;
  logic [AMT_W-1:0]    rem_after;
  logic [DATA_W-1:0]   step_data;

  assign step_k    = step_amount(32'(rem_q));
  assign rem_after = rem_q - AMT_W'(step_k);

  shift_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .data     (acc_q),
    .k        (step_k),
    .left     (mode_q[MODE_LEFT]),
    .arith    (mode_q[MODE_ARITH]),
    .shift    (mode_q[MODE_SHIFT]),
    .data_out (step_data)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d             = in_data;
          rem_d             = in_amt;
          mode_d[MODE_LEFT]  = in_left;
          mode_d[MODE_ARITH] = in_arith;
          mode_d[MODE_SHIFT] = in_shift;
          state_d           = ST_RUN;
        end
      end
      ST_RUN: begin
        // A zero amount still spends this cycle and passes acc through (k=0).
        acc_d = step_data;
        rem_d = rem_after;
        if (rem_after == '0) begin
          out_data_d  = step_data;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      mode_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // The result flag and the DONE state must always travel together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (out_valid_q == (state_q == ST_DONE))
        else $error("out_valid out of step with DONE state");
    end
  end

endmodule
